// File: rtl/m1_wr_outstanding_slice.sv
// M1 write-path slice: AW goes through a 2-entry skid buffer and is throttled by an
// outstanding-write counter. B passes straight through, and a B with nothing in flight raises a sticky flag.
module m1_wr_outstanding_slice #(
  parameter int ID_W            = 4,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   M1_AWID,
  input  logic [ADDR_W-1:0] M1_AWADDR,
  input  logic [LEN_W-1:0]  M1_AWLEN,
  input  logic [2:0]        M1_AWSIZE,
  input  logic [1:0]        M1_AWBURST,
  input  logic              M1_AWVALID,
  output logic              M1_AWREADY,
  output logic [ID_W-1:0]   N_AWID,
  output logic [ADDR_W-1:0] N_AWADDR,
  output logic [LEN_W-1:0]  N_AWLEN,
  output logic [2:0]        N_AWSIZE,
  output logic [1:0]        N_AWBURST,
  output logic              N_AWVALID,
  input  logic              N_AWREADY,
  input  logic [ID_W-1:0]   N_BID,
  input  logic [1:0]        N_BRESP,
  input  logic              N_BVALID,
  output logic              N_BREADY,
  output logic [ID_W-1:0]   M1_BID,
  output logic [1:0]        M1_BRESP,
  output logic              M1_BVALID,
  input  logic              M1_BREADY,
  output logic [CNT_W-1:0]  outstanding_cnt,
  output logic              limit_reached,
  output logic              b_underflow_err
);

  localparam int PW = ID_W + ADDR_W + LEN_W + 3 + 2;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  skid_state_t      r_state;
  skid_state_t      w_nextState;
  logic [PW-1:0]    r_main;
  logic [PW-1:0]    r_skid;
  logic [PW-1:0]    w_in;
  logic             w_loadMainIn;
  logic             w_loadMainSkid;
  logic             w_loadSkid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_rdyEn;
  logic             w_upAw;
  logic             w_dnAw;
  logic             w_bHs;

  assign w_in = {M1_AWID, M1_AWADDR, M1_AWLEN, M1_AWSIZE, M1_AWBURST};

  // r_rdyEn keeps AWREADY low in reset while still deriving it from flops only
  assign M1_AWREADY = r_rdyEn && (r_state != TWO) && (r_cnt < MAX_C);
  assign N_AWVALID  = (r_state != EMPTY);
  assign {N_AWID, N_AWADDR, N_AWLEN, N_AWSIZE, N_AWBURST} = r_main;

  assign w_upAw = M1_AWVALID && M1_AWREADY;
  assign w_dnAw = N_AWVALID && N_AWREADY;
  assign w_bHs  = M1_BVALID && M1_BREADY;

  assign M1_BID    = N_BID;
  assign M1_BRESP  = N_BRESP;
  assign M1_BVALID = N_BVALID;
  assign N_BREADY  = M1_BREADY;

  assign outstanding_cnt = r_cnt;
  assign limit_reached   = (r_cnt == MAX_C);
  assign b_underflow_err = r_err;

  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_upAw) begin
          w_nextState  = ONE;
          w_loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (w_upAw && !w_dnAw) begin
          w_nextState = TWO;
          w_loadSkid  = 1'b1;
        end else if (w_dnAw && !w_upAw) begin
          w_nextState = EMPTY;
        end else if (w_upAw && w_dnAw) begin
          w_loadMainIn = 1'b1;
        end
      end
      TWO: begin
        if (w_dnAw) begin
          w_nextState    = ONE;
          w_loadMainSkid = 1'b1;
        end
      end
      default: w_nextState = EMPTY;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_rdyEn <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_rdyEn <= 1'b1;
      if (w_loadMainIn) begin
        r_main <= w_in;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= w_in;
      end
    end
  end

  // A B with nothing in flight saturates the count at zero and latches the error
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_upAw && !w_bHs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_bHs && !w_upAw && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_bHs && (r_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
